// File: rtl/si_po_shift_reg_pkg.sv
// Shared constants and helpers for the serial-in / parallel-out shift register.
// The fill-counter width helper is only used when SIPO_FILL_FLAG_EN is defined.
package sipo_pkg;

    localparam int SIPO_DEFAULT_WIDTH = 8;
    localparam logic [63:0] SIPO_DEFAULT_RST_VAL = 64'h0;

    // Bits needed to count 0..width inclusive.
    function automatic int sipo_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/si_po_shift_reg_if.sv
// Serial input / parallel output bundle of the shift register.
// The full flag exists only when SIPO_FILL_FLAG_EN is defined.
interface si_po_shift_reg_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
) ();

    logic             SI;
    logic [WIDTH-1:0] PO;
`ifdef SIPO_FILL_FLAG_EN
    logic             full;
`endif

`ifdef SIPO_FILL_FLAG_EN
    modport master (output SI, input PO, input full);
    modport slave  (input SI, output PO, output full);
`else
    modport master (output SI, input PO);
    modport slave  (input SI, output PO);
`endif

endinterface

// File: rtl/si_po_shift_reg_fill_counter.sv
// Saturating fill counter: counts shift edges up to MAX, flags full once saturated.
// Instantiated by si_po_shift_reg only when SIPO_FILL_FLAG_EN is defined.
module sipo_fill_counter #(
    parameter int MAX = 8,
    parameter int CW  = 4
) (
    input  logic clk,
    input  logic rst,
    output logic full
);

    localparam logic [CW-1:0] MAX_V = CW'(MAX);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          full_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_reg != MAX_V) begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    // Flag is computed from the next count so it rises on the same edge the count saturates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg  <= '0;
            full_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            full_reg <= (cnt_next == MAX_V);
        end
    end

    assign full = full_reg;

endmodule

// File: rtl/si_po_shift_reg.sv
// Serial-in, parallel-out shift register: new bit enters PO[0] every clock, oldest leaves PO[WIDTH-1].
// Defining SIPO_FILL_FLAG_EN adds a registered full flag driven by sipo_fill_counter.
module si_po_shift_reg
    import sipo_pkg::*;
#(
    parameter int               WIDTH   = SIPO_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = SIPO_DEFAULT_RST_VAL[WIDTH-1:0]
) (
    input  logic               clk,
    input  logic               rst,
    si_po_shift_reg_if.slave   bus
);

    logic [WIDTH-1:0] po_reg;
    logic [WIDTH-1:0] po_next;

    assign po_next[0] = bus.SI;

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_stage
            assign po_next[gi] = po_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            po_reg <= RST_VAL;
        end else begin
            po_reg <= po_next;
        end
    end

    assign bus.PO = po_reg;

`ifdef SIPO_FILL_FLAG_EN
    sipo_fill_counter #(
        .MAX (WIDTH),
        .CW  (sipo_cnt_width(WIDTH))
    ) u_fill (
        .clk  (clk),
        .rst  (rst),
        .full (bus.full)
    );
`endif

endmodule

// File: tb/tb_si_po_shift_reg.sv
// Scoreboard bench for si_po_shift_reg: an 8-bit and a 4-bit instance share clk/rst/SI;
// stimulus pushes hand-computed expectations, a monitor pops and checks one entry per edge.
module tb_si_po_shift_reg;

    typedef struct {
        logic [7:0] exp8;
        logic [3:0] exp4;
        logic       chk4;
        logic       expfull;
        string      name;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    sb_entry_t sb[$];
    int vectors    = 0;
    int miscompare = 0;

    si_po_shift_reg_if #(.WIDTH(8)) bus8 ();
    si_po_shift_reg_if #(.WIDTH(4)) bus4 ();

    si_po_shift_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    si_po_shift_reg #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    // Drive one edge's inputs away from posedge and record what must be seen after it.
    task automatic step(input logic rst_v, input logic si_v, input logic [7:0] e8,
                        input logic ef, input logic c4, input logic [3:0] e4, input string nm);
        sb_entry_t e;
        @(negedge clk);
        rst     = rst_v;
        bus8.SI = si_v;
        bus4.SI = si_v;
        e.exp8 = e8; e.exp4 = e4; e.chk4 = c4; e.expfull = ef; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: the register presents a new value after every edge.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (bus8.PO !== e.exp8) begin
                    miscompare++;
                    $display("FAIL %s: PO8 got %h expected %h", e.name, bus8.PO, e.exp8);
                end else begin
                    $display("ok   %s: PO8 = %h", e.name, bus8.PO);
                end
                if (e.chk4) begin
                    vectors++;
                    if (bus4.PO !== e.exp4) begin
                        miscompare++;
                        $display("FAIL %s: PO4 got %h expected %h", e.name, bus4.PO, e.exp4);
                    end else begin
                        $display("ok   %s: PO4 = %h", e.name, bus4.PO);
                    end
                end
`ifdef SIPO_FILL_FLAG_EN
                vectors++;
                if (bus8.full !== e.expfull) begin
                    miscompare++;
                    $display("FAIL %s: full got %b expected %b", e.name, bus8.full, e.expfull);
                end
`endif
            end
        end
    end

    initial begin
        logic [7:0] load_si;
        logic [7:0] load_po [8];
        logic [7:0] ovf_po  [8];
        load_si = 8'b1011_0010;
        load_po = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
        ovf_po  = '{8'h65, 8'hCB, 8'h97, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF};
        bus8.SI = 1'b0;
        bus4.SI = 1'b0;

        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, "reset_a");
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, "reset_b");

        for (int i = 0; i < 8; i++) begin
            step(1'b1, load_si[7-i], load_po[i], (i == 7), 1'b0, 4'h0,
                 $sformatf("load_%0d", i + 1));
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, ovf_po[i], 1'b1, 1'b0, 4'h0, $sformatf("overflow_%0d", i + 1));
        end

        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, "reset_c");
        step(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 4'h0, "ones_1");
        step(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 4'h0, "ones_2");
        step(1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 4'h0, "ones_3");
        step(1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 4'h0, "ones_4");
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, "midreset");
        step(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 4'h0, "resume");

        // Width sweep: both instances checked from a common reset.
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 4'h0, "w4_reset");
        step(1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 4'h1, "w4_1");
        step(1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 4'h3, "w4_2");
        step(1'b1, 1'b0, 8'h06, 1'b0, 1'b1, 4'h6, "w4_3");
        step(1'b1, 1'b1, 8'h0D, 1'b0, 1'b1, 4'hD, "w4_4");
        step(1'b1, 1'b0, 8'h1A, 1'b0, 1'b1, 4'hA, "w4_5");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            vectors++;
            miscompare++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompare);
        $finish;
    end

endmodule

// File: doc/si_po_shift_reg.md
Name: si_po_shift_reg

Overview:
- 8-bit (parameterisable) serial-in, parallel-out shift register.
- Samples one serial bit per rising clock edge and presents the last WIDTH bits in parallel.
- Used as a deserialiser front-end; purely synchronous, single clock domain, no handshake.

Parameters:
- WIDTH, 8, number of register stages and width of PO (legal range 2..64).
- RST_VAL, all zeros (WIDTH'b0), value loaded into the register on reset.

Ports:
- clk  input  1  rising-edge clock; sole clock of the block.
- rst  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- SI   input  1  serial data in, sampled every rising clk edge.
- PO   output WIDTH  parallel data out; direct register output, no combinational path from SI.

Behaviour:
- One clock; reset is synchronous and active-low (rst, sampled on rising clk).
- Reset: on a rising clk edge with rst==0, PO <= RST_VAL (8'h00 by default). SI is ignored in that cycle.
- Shift: on a rising clk edge with rst==1, PO <= {PO[WIDTH-2:0], SI}.
  - The new bit enters at PO[0].
  - The oldest bit leaves from PO[WIDTH-1] and is discarded.
- No enable: shifting happens on every non-reset cycle.
- Latency: SI sampled at edge n appears at PO[0] after edge n and at PO[k] after edge n+k.
- After WIDTH consecutive shifts, PO holds the last WIDTH SI samples, most recent at bit 0.
- Before any reset, PO is X in simulation. No power-on initialiser is required.
- Reset mid-stream: the contents clear on that edge, and shifting resumes from RST_VAL on the next non-reset edge.
- Reset overrides shift when both would apply.
- PO changes only on clock edges; it is glitch-free relative to SI.

Optional Feature:
- Macro SIPO_FILL_FLAG_EN.
- Defined:
  - Adds output port full (1 bit) and an internal fill counter, width clog2(WIDTH+1).
  - The counter resets to 0 with rst==0.
  - It increments on each shift edge and saturates at WIDTH.
  - full==1 when the counter equals WIDTH, meaning PO contains no reset bits.
  - full is registered and deasserts on reset.
- Not defined: no full port, no counter. Core behaviour is identical in both builds.

Decomposition:
- Shared package sipo_pkg holds:
  - constant SIPO_DEFAULT_WIDTH = 8;
  - the default reset value constant;
  - the counter-width helper used when SIPO_FILL_FLAG_EN is set.
- Optional sub-module sipo_fill_counter (saturating up-counter with synchronous active-low clear), instantiated only under SIPO_FILL_FLAG_EN.
- The shift register itself stays in the top module.

Test Plan:
- Reset: hold rst=0 for 2 edges with SI=1 -> PO==8'h00 (and full==0 if enabled).
- Serial load: release rst, drive SI=1,0,1,1,0,0,1,0 on 8 edges -> PO==8'b10110010 (8'hB2). Intermediate value after 3 edges == 8'h05.
- Overflow: continue 8 more edges with SI=1 -> PO==8'hFF. The earlier bits are fully discarded; after the first extra edge PO==8'h65.
- Mid-stream reset: after 4 shifts of SI=1 (PO==8'h0F), assert rst=0 for one edge with SI=1 -> PO==8'h00. The next edge with SI=1 gives PO==8'h01.
- Fill flag (SIPO_FILL_FLAG_EN):
  - after reset, full==0 for edges 1..7 and full==1 after edge 8;
  - it stays 1 on further shifts;
  - it returns to 0 on reset.
- Width sweep: WIDTH=4, SI=1,1,0,1 -> PO==4'b1101. One more SI=0 -> PO==4'b1010.
